rv32_fetch_seq: RTL and testbench
=================================

Name: rv32_fetch_seq

Overview:
- Sequential front end that drives the combinational RV32 execute core.
- Owns the architectural PC, fetches each instruction over a valid/ready instruction-memory port, and holds it in a one-entry buffer.
- Presents insn/insn_valid to the core, then commits pc_next when the core reports completion.
- Also owns the 64-bit cycle and instret counters that the core reads as CSRs, and halts permanently on trap.

Parameters:
- PROGADDR_RESET, 32'h0000_0000, PC value loaded at reset.
- ENABLE_COUNTERS, 1, when 0, csr_cycle and csr_instret are tied to 0.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous reset, active-low
- imem_valid  out  1  fetch request
- imem_addr  out  32  fetch address, equal to {pc[31:2],2'b00}
- imem_ready  in  1  fetch data accepted/returned this cycle
- imem_rdata  in  32  fetched instruction word
- pc  out  32  current architectural PC, to core
- insn  out  32  buffered instruction, to core
- insn_valid  out  1  insn is valid for execution
- insn_complete  in  1  core finished the instruction this cycle
- pc_next  in  32  core's next PC
- pc_next_valid  in  1  pc_next is usable
- trap  in  1  core trap
- csr_cycle  out  64  cycle counter
- csr_instret  out  64  retired-instruction counter
- halted  out  1  sticky halt after trap

Behaviour:
- Reset (async, resetn=0): effects are immediate on assertion.
  - state=FETCH, pc=PROGADDR_RESET, insn=0, insn_valid=0, imem_valid=0, csr_cycle=0, csr_instret=0, halted=0.
  - Any in-flight fetch is abandoned.
- First cycle after reset release: imem_valid=1 with imem_addr={pc[31:2],00}.
- FETCH state:
  - imem_valid=1 with a constant imem_addr until imem_ready is sampled high.
  - On imem_ready: insn<=imem_rdata, insn_valid<=1, imem_valid<=0, go EXEC.
  - Latency: insn_valid rises 1 cycle after the imem_ready cycle.
- EXEC state: insn_valid=1 and insn stays stable.
  - insn_complete=1, trap=0, pc_next_valid=1: pc<=pc_next, csr_instret+=1, insn_valid<=0, go FETCH; the next fetch issues the following cycle.
  - insn_complete=1 and trap=1: pc holds, csr_instret does not increment, insn_valid<=0, halted<=1, go HALT.
  - insn_complete=1, trap=0, pc_next_valid=0: illegal core combination; stay in EXEC, no commit.
  - insn_complete=0: stay in EXEC. This covers a stalled memory access or register-file access in the core.
- HALT state: terminal until reset. imem_valid=0, insn_valid=0, halted=1; pc, insn and csr_instret are frozen.
- Counters:
  - csr_cycle increments every clock after reset, including in HALT.
  - Both counters are 64-bit unsigned and wrap modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF+1 gives 0.
  - csr_cycle and csr_instret values are registered; the core sees the pre-increment value in the retiring cycle.
- Misaligned pc_next is committed as given; the core traps on it.
- Throughput without bypass: at least 2 cycles per instruction when imem_ready and insn_complete are both immediate.

Optional Feature:
- Macro RV32_FETCH_BYPASS_EN.
- When defined, FETCH forwards data combinationally: insn_valid=imem_ready and insn=imem_rdata in the imem_ready cycle.
  - If insn_complete is also high in that cycle, commit exactly as EXEC does and remain in FETCH with the new address the next cycle (1 cycle per instruction).
  - Otherwise latch imem_rdata and go to EXEC.
- When undefined: registered-only path as described above.

Decomposition:
- Package rv32_pkg:
  - state enum {FETCH, EXEC, HALT}
  - XLEN=32
  - CNT_W=64
  - RESET_PC default constant
- One natural sub-module: rv32_csr_counters, holding csr_cycle and csr_instret with inputs retire and enable, shared with future pipelined cores.

Test Plan:
- Reset release, PROGADDR_RESET=32'h100, imem_ready after 3 cycles with rdata 32'h00500093 -> imem_addr=32'h100 held stable for 3 cycles; insn_valid=1 the next cycle with insn=32'h00500093.
- EXEC with insn_complete=1, pc_next=32'h104, pc_next_valid=1 -> pc=32'h104, csr_instret=1, imem_valid=1 at addr 32'h104 the following cycle.
- EXEC with insn_complete held low for 5 cycles -> insn, pc and instret unchanged; then commit on completion.
- EXEC with trap=1, insn_complete=1 -> halted=1, pc unchanged, instret unchanged, imem_valid stays 0 for 20 cycles while csr_cycle keeps counting.
- resetn pulsed low mid-FETCH with imem_valid=1 -> imem_valid drops in the same cycle; restart at PROGADDR_RESET with counters at 0.
- Force csr_instret=64'hFFFF_FFFF_FFFF_FFFF and retire one instruction -> csr_instret=0. With RV32_FETCH_BYPASS_EN and ready/complete always high -> one retire per cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared types and constants for the RV32 fetch sequencer and
//                its CSR counter block.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  // Default PC loaded at reset when the parent does not override it.
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Sequencer states: fetch a word, wait for the core, or stop after a trap.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Instruction memory is word addressed; the low PC bits never reach it.
  function automatic logic [XLEN-1:0] fetch_addr(input logic [XLEN-1:0] pc_val);
    return {pc_val[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_csr_counters.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_csr_counters
//  Description : 64-bit cycle and retired-instruction counters read by the
//                core as CSRs. Values are registered, so a retiring
//                instruction observes the pre-increment count. Both counters
//                wrap modulo 2^64. When enable is low both read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_csr_counters
  import rv32_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             retire,
  output logic [CNT_W-1:0] csr_cycle,
  output logic [CNT_W-1:0] csr_instret
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  // Free-running cycle count plus a retire-qualified instruction count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else if (!enable) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign csr_cycle   = r_cycle;
  assign csr_instret = r_instret;

endmodule
`default_nettype wire

// File: rtl/rv32_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_fetch_seq
//  Description : Sequential front end for the combinational RV32 execute
//                core. Owns the architectural PC, fetches over a valid/ready
//                port into a one-entry buffer, commits pc_next on completion,
//                keeps the cycle/instret CSRs and halts for good on trap.
//                Optional macro RV32_FETCH_BYPASS_EN forwards the fetched
//                word straight to the core in the imem_ready cycle, giving
//                one instruction per cycle when memory and core are immediate.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_fetch_seq
  import rv32_pkg::*;
#(
  parameter logic [31:0] PROGADDR_RESET  = RESET_PC,
  parameter int          ENABLE_COUNTERS = 1
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             imem_valid,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  insn,
  output logic             insn_valid,
  input  logic             insn_complete,
  input  logic [XLEN-1:0]  pc_next,
  input  logic             pc_next_valid,
  input  logic             trap,
  output logic [CNT_W-1:0] csr_cycle,
  output logic [CNT_W-1:0] csr_instret,
  output logic             halted
);

  state_t          r_state;
  state_t          w_state_next;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_insn;
  logic            r_insn_valid;
  logic            r_halted;

  logic            w_retire;
  logic            w_trap_hit;
  logic            w_load_insn;

  // State register; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode. An illegal complete-without-pc_next leaves us in EXEC.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: begin
        if (imem_ready) begin
`ifdef RV32_FETCH_BYPASS_EN
          if (insn_complete && trap) begin
            w_state_next = HALT;
          end else if (insn_complete && pc_next_valid) begin
            w_state_next = FETCH;
          end else begin
            w_state_next = EXEC;
          end
`else
          w_state_next = EXEC;
`endif
        end
      end
      EXEC: begin
        if (insn_complete) begin
          if (trap) begin
            w_state_next = HALT;
          end else if (pc_next_valid) begin
            w_state_next = FETCH;
          end
        end
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
  end

  // Output decode: memory request, core-facing instruction and commit strobes.
  always_comb begin
    imem_valid  = 1'b0;
    insn_valid  = r_insn_valid;
    insn        = r_insn;
    w_retire    = 1'b0;
    w_trap_hit  = 1'b0;
    w_load_insn = 1'b0;
    case (r_state)
      FETCH: begin
        // Gated by resetn so the request drops the instant reset asserts.
        imem_valid  = resetn;
        w_load_insn = imem_ready;
`ifdef RV32_FETCH_BYPASS_EN
        if (imem_ready && resetn) begin
          insn_valid = 1'b1;
          insn       = imem_rdata;
          w_retire   = insn_complete && !trap && pc_next_valid;
          w_trap_hit = insn_complete && trap;
        end
`endif
      end
      EXEC: begin
        w_retire   = insn_complete && !trap && pc_next_valid;
        w_trap_hit = insn_complete && trap;
      end
      default: begin
      end
    endcase
  end

  // Architectural PC, instruction buffer and sticky halt flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc         <= PROGADDR_RESET;
      r_insn       <= '0;
      r_insn_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      if (w_load_insn) begin
        r_insn <= imem_rdata;
      end
      // Misaligned targets are committed as given; the core traps on them.
      if (w_retire) begin
        r_pc <= pc_next;
      end
      if (w_trap_hit) begin
        r_halted <= 1'b1;
      end
      r_insn_valid <= (w_state_next == EXEC);
    end
  end

  assign imem_addr = fetch_addr(r_pc);
  assign pc        = r_pc;
  assign halted    = r_halted;

  rv32_csr_counters u_csr (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (ENABLE_COUNTERS != 0),
    .retire      (w_retire),
    .csr_cycle   (csr_cycle),
    .csr_instret (csr_instret)
  );

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_fetch_seq
//  Description : Directed self-checking bench for rv32_fetch_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_fetch_seq;

`ifdef RV32_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        insn_valid;
  logic        insn_complete = 1'b0;
  logic [31:0] pc_next;
  logic        pc_next_valid = 1'b0;
  logic        trap = 1'b0;
  logic [63:0] csr_cycle;
  logic [63:0] csr_instret;
  logic        halted;

  logic        auto_next = 1'b0;
  logic [31:0] pc_next_drv = 32'h0;
  logic [63:0] exp_cycle;
  int          n_checks = 0;
  int          n_pass = 0;

  // Sequential-PC stimulus for the throughput run, manual target otherwise.
  assign pc_next = auto_next ? pc + 32'd4 : pc_next_drv;

  always #5 clk = ~clk;

  // Reference cycle count: one per clock while out of reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) exp_cycle <= 64'd0;
    else         exp_cycle <= exp_cycle + 64'd1;
  end

  rv32_fetch_seq #(
    .PROGADDR_RESET  (32'h0000_0100),
    .ENABLE_COUNTERS (1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .imem_valid    (imem_valid),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .insn          (insn),
    .insn_valid    (insn_valid),
    .insn_complete (insn_complete),
    .pc_next       (pc_next),
    .pc_next_valid (pc_next_valid),
    .trap          (trap),
    .csr_cycle     (csr_cycle),
    .csr_instret   (csr_instret),
    .halted        (halted)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) step();
    #1;
    n_checks++;
    if ({imem_valid, insn_valid, halted} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {imem_valid, insn_valid, halted});
    else n_pass++;
    n_checks++;
    if (pc !== 32'h100) $display("FAIL reset_pc got=%h exp=00000100", pc);
    else n_pass++;
    n_checks++;
    if (insn !== 32'h0) $display("FAIL reset_insn got=%h exp=00000000", insn);
    else n_pass++;
    n_checks++;
    if ({csr_cycle, csr_instret} !== 128'd0)
      $display("FAIL reset_counters got=%h/%h exp=0/0", csr_cycle, csr_instret);
    else n_pass++;
  endtask

  task automatic test_fetch;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({imem_valid, imem_addr, insn_valid} !== {1'b1, 32'h100, 1'b0})
        $display("FAIL fetch_wait%0d got=%b/%h/%b exp=1/00000100/0", i, imem_valid, imem_addr, insn_valid);
      else n_pass++;
      step();
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0093;
    #1;
    n_checks++;
    if ({imem_valid, insn_valid} !== {1'b1, BYP})
      $display("FAIL fetch_ready_cycle got=%b/%b exp=1/%b", imem_valid, insn_valid, BYP);
    else n_pass++;
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({insn_valid, insn, imem_valid} !== {1'b1, 32'h0050_0093, 1'b0})
      $display("FAIL fetch_insn got=%b/%h/%b exp=1/00500093/0", insn_valid, insn, imem_valid);
    else n_pass++;
    n_checks++;
    if (csr_cycle !== 64'd4) $display("FAIL fetch_cycle got=%0d exp=4", csr_cycle);
    else n_pass++;
  endtask

  task automatic test_commit;
    insn_complete = 1'b1;
    pc_next_drv   = 32'h104;
    pc_next_valid = 1'b1;
    #1;
    n_checks++;
    if (csr_instret !== 64'd0) $display("FAIL commit_pre_instret got=%0d exp=0", csr_instret);
    else n_pass++;
    step();
    insn_complete = 1'b0;
    pc_next_valid = 1'b0;
    #1;
    n_checks++;
    if ({pc, csr_instret} !== {32'h104, 64'd1})
      $display("FAIL commit_pc_instret got=%h/%0d exp=00000104/1", pc, csr_instret);
    else n_pass++;
    n_checks++;
    if ({imem_valid, imem_addr, insn_valid} !== {1'b1, 32'h104, 1'b0})
      $display("FAIL commit_refetch got=%b/%h/%b exp=1/00000104/0", imem_valid, imem_addr, insn_valid);
    else n_pass++;
  endtask

  task automatic test_stall;
    imem_ready = 1'b1;
    imem_rdata = 32'h00A0_0113;
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({insn_valid, insn, pc, csr_instret} !== {1'b1, 32'h00A0_0113, 32'h104, 64'd1})
        $display("FAIL stall%0d got=%b/%h/%h/%0d exp=1/00a00113/00000104/1", i, insn_valid, insn, pc, csr_instret);
      else n_pass++;
      step();
    end
    insn_complete = 1'b1;
    pc_next_valid = 1'b0;
    pc_next_drv   = 32'h108;
    step();
    #1;
    n_checks++;
    if ({insn_valid, pc, csr_instret} !== {1'b1, 32'h104, 64'd1})
      $display("FAIL stall_illegal got=%b/%h/%0d exp=1/00000104/1", insn_valid, pc, csr_instret);
    else n_pass++;
    pc_next_valid = 1'b1;
    step();
    insn_complete = 1'b0;
    pc_next_valid = 1'b0;
    #1;
    n_checks++;
    if ({pc, csr_instret, imem_valid} !== {32'h108, 64'd2, 1'b1})
      $display("FAIL stall_commit got=%h/%0d/%b exp=00000108/2/1", pc, csr_instret, imem_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_pc;
    logic [63:0] exp_ir;
    exp_pc = BYP ? 32'h128 : 32'h118;
    exp_ir = BYP ? 64'd10 : 64'd6;
    auto_next     = 1'b1;
    imem_ready    = 1'b1;
    imem_rdata    = 32'h0000_0013;
    insn_complete = 1'b1;
    pc_next_valid = 1'b1;
    repeat (8) step();
    #1;
    n_checks++;
    if ({pc, csr_instret} !== {exp_pc, exp_ir})
      $display("FAIL b2b_rate got=%h/%0d exp=%h/%0d", pc, csr_instret, exp_pc, exp_ir);
    else n_pass++;
    n_checks++;
    if (csr_cycle !== exp_cycle) $display("FAIL b2b_cycle got=%0d exp=%0d", csr_cycle, exp_cycle);
    else n_pass++;
    auto_next     = 1'b0;
    imem_ready    = 1'b0;
    insn_complete = 1'b0;
    pc_next_valid = 1'b0;
  endtask

  task automatic test_wrap;
    force dut.u_csr.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_csr.r_instret;
    #1;
    n_checks++;
    if (csr_instret !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL wrap_preload got=%h exp=ffffffffffffffff", csr_instret);
    else n_pass++;
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_ready    = 1'b0;
    insn_complete = 1'b1;
    pc_next_valid = 1'b1;
    pc_next_drv   = 32'h202;
    step();
    insn_complete = 1'b0;
    pc_next_valid = 1'b0;
    #1;
    n_checks++;
    if (csr_instret !== 64'd0) $display("FAIL wrap_instret got=%h exp=0", csr_instret);
    else n_pass++;
    n_checks++;
    if ({pc, imem_valid, imem_addr} !== {32'h202, 1'b1, 32'h200})
      $display("FAIL misaligned_pc got=%h/%b/%h exp=00000202/1/00000200", pc, imem_valid, imem_addr);
    else n_pass++;
  endtask

  task automatic test_trap;
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0073;
    step();
    imem_ready    = 1'b0;
    insn_complete = 1'b1;
    trap          = 1'b1;
    step();
    insn_complete = 1'b0;
    trap          = 1'b0;
    imem_ready    = 1'b1;
    #1;
    n_checks++;
    if ({halted, pc, csr_instret, insn_valid, imem_valid} !== {1'b1, 32'h202, 64'd0, 1'b0, 1'b0})
      $display("FAIL trap_enter got=%b/%h/%0d/%b/%b exp=1/00000202/0/0/0", halted, pc, csr_instret, insn_valid, imem_valid);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      n_checks++;
      if ({imem_valid, insn_valid, halted} !== 3'b001)
        $display("FAIL halt_hold%0d got=%b exp=001", i, {imem_valid, insn_valid, halted});
      else n_pass++;
    end
    n_checks++;
    if ({pc, insn, csr_instret} !== {32'h202, 32'h0000_0073, 64'd0})
      $display("FAIL halt_frozen got=%h/%h/%0d exp=00000202/00000073/0", pc, insn, csr_instret);
    else n_pass++;
    n_checks++;
    if (csr_cycle !== exp_cycle) $display("FAIL halt_cycle got=%0d exp=%0d", csr_cycle, exp_cycle);
    else n_pass++;
    imem_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    n_checks++;
    if ({imem_valid, imem_addr, halted} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL rst_release got=%b/%h/%b exp=1/00000100/0", imem_valid, imem_addr, halted);
    else n_pass++;
    @(posedge clk);
    #2;
    n_checks++;
    if (csr_cycle !== 64'd1) $display("FAIL rst_precount got=%0d exp=1", csr_cycle);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({imem_valid, insn_valid, pc, csr_cycle, csr_instret} !== {1'b0, 1'b0, 32'h100, 64'd0, 64'd0})
      $display("FAIL rst_async got=%b/%b/%h/%0d/%0d exp=0/0/00000100/0/0", imem_valid, insn_valid, pc, csr_cycle, csr_instret);
    else n_pass++;
    step();
    resetn = 1'b1;
    step();
    #1;
    n_checks++;
    if ({imem_valid, imem_addr, csr_cycle} !== {1'b1, 32'h100, 64'd1})
      $display("FAIL rst_restart got=%b/%h/%0d exp=1/00000100/1", imem_valid, imem_addr, csr_cycle);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_commit();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_trap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
`default_nettype wire
